ft245_device: RTL and testbench
===============================

FT245_DEVICE -- requirements
Module: ft245_device

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, _reset.
REQ-002 Parameter DEPTH, default 16: entries per internal byte FIFO, power of two, minimum 4.
REQ-003 clk  input  1  bus clock; all bus sampling on rising edge.
REQ-004 _reset  input  1  asynchronous active-low reset.
REQ-005 _rd  input  1  host read strobe, active low.
REQ-006 _wr  input  1  host write strobe, active low.
REQ-007 _oe  input  1  host output-enable request, active low.
REQ-008 _rxf  output  1  low = RX FIFO holds data for host.
REQ-009 _txe  output  1  low = TX FIFO can accept a byte from host.
REQ-010 data  inout  8  shared bus; driven by device only when drive_en=1, else high-Z.
REQ-011 pc_in_data  input  8  byte from PC side, pushed into RX FIFO.
REQ-012 pc_in_valid / pc_in_ready  input / output  1 each  push handshake; transfer on edge with both high.
REQ-013 pc_out_data  output  8  TX FIFO head byte.
REQ-014 pc_out_valid / pc_out_ready  output / input  1 each  pop handshake; transfer on edge with both high.
REQ-015 proto_err  output  3  sticky flags: [0] rd_no_oe, [1] wr_when_full, [2] rd_wr_together.

Function
REQ-016 pc_in_ready SHALL equal RX FIFO not full; pc_out_valid SHALL equal TX FIFO not empty; both combinational from FIFO state only.
REQ-017 _rxf and _txe SHALL be registered: _rxf = RX empty, _txe = TX full, evaluated on post-edge FIFO contents; a pc_in push into an empty RX FIFO drives _rxf low on the same edge.
REQ-018 Bus FSM states: B_IDLE, B_TURN, B_DRIVE; state encodings in package.
REQ-019 B_IDLE: _oe sampled low -> B_TURN; else stay.
REQ-020 B_TURN: drive_en=0 (turnaround); _oe low -> B_DRIVE; _oe high -> B_IDLE.
REQ-021 B_DRIVE: drive_en=1; data = RX FIFO head (0x00 if empty); _oe sampled high -> B_IDLE, drive_en deasserted on that same edge.
REQ-022 Host read: on edge with state B_DRIVE, _rd=0, _rxf=0, _wr=1: pop RX FIFO; new head on data next cycle; consecutive-cycle reads pop one byte per clock.
REQ-023 _rd=0 in B_IDLE or B_TURN: no pop; set proto_err[0].
REQ-024 Host write: on edge with _wr=0, _txe=0, _rd=1, state B_IDLE: push data into TX FIFO; one byte per clock while held.
REQ-025 _wr=0 with _txe=1: byte dropped, set proto_err[1]; _wr=0 in B_TURN/B_DRIVE: dropped, set proto_err[1].
REQ-026 _rd=0 and _wr=0 same edge: neither transfer, set proto_err[2].
REQ-027 Simultaneous bus pop and pc_in push on RX FIFO SHALL both succeed; when full, push rejected (pc_in_ready already low).
REQ-028 Simultaneous bus push and pc_out pop on TX FIFO SHALL both succeed; full/empty and pointers wrap modulo DEPTH with an extra pointer bit to distinguish full from empty.
REQ-029 proto_err bits SHALL clear only on reset.

Reset
REQ-030 On _reset low, immediately: both FIFOs empty, state B_IDLE, drive_en=0 (data high-Z), _rxf=1, _txe=1, proto_err=0.
REQ-031 First edge after reset release SHALL set _txe=0; _rxf stays 1 until a pc_in push.
REQ-032 Reset asserted mid-burst SHALL discard in-flight bytes and release the bus within zero clocks.

Structure
REQ-033 Package ft245_pkg SHALL hold bus FSM state constants, proto_err bit indices, and default DEPTH.
REQ-034 One sub-module, ft245_byte_fifo (DEPTH-parameterised, push/pop/full/empty/head), instantiated twice (RX, TX).

Verification
REQ-035 Reset, push 0xA5 on pc_in -> _rxf low next edge; host _oe low 2 cycles, _rd low 1 cycle -> host captures 0xA5, _rxf returns high.
REQ-036 Host writes 0x01..0x10 with _wr held low 16 cycles, DEPTH=16 -> all accepted, _txe high after 16th; pc_out drains 0x01..0x10 in order.
REQ-037 17th write attempt with _txe high -> byte dropped, proto_err=3'b010, TX contents unchanged.
REQ-038 _rd low with _oe high -> no pop, proto_err[0]=1, data high-Z.
REQ-039 RX full (16 bytes), host burst-reads while pc_in pushes 0x77 each cycle -> every byte delivered once in order, no loss.
REQ-040 _reset asserted during B_DRIVE read burst -> data high-Z same cycle, _rxf=1, _txe=1, FIFOs empty.

Source files
------------

// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared constants for the FT245-style device
// Purpose: bus FSM state encodings, proto_err bit indices and the default FIFO depth.
package ft245_pkg;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_TURN  = 2'd1,
    B_DRIVE = 2'd2
  } bus_state_e;

  localparam int ERR_RD_NO_OE = 0;
  localparam int ERR_WR_FULL  = 1;
  localparam int ERR_RD_WR    = 2;

  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/ft245_byte_fifo.sv
// rtl/ft245_byte_fifo.sv - byte FIFO with wrap-bit pointers
// Purpose: DEPTH-entry byte queue; push is ignored when full, pop when empty.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push_i, push_data_i  write request and byte
//   pop_i                read request
//   head_o               oldest byte (undefined when empty)
//   full_o, empty_o      current state
//   full_next_o, empty_next_o  state after this edge's push/pop
module ft245_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       full_next_o,
  output logic       empty_next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  // Extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // A push into a full FIFO is rejected even if a pop frees a slot this edge.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

  assign full_next_o  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign empty_next_o = (wr_ptr_d == rd_ptr_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ft245_device.sv
// rtl/ft245_device.sv - FT245-style asynchronous FIFO device, clocked model
// Purpose: host-side strobe bus in front of an RX FIFO (PC -> host) and a TX FIFO (host -> PC).
// Ports:
//   clk, _reset               clock, asynchronous active-low reset
//   _rd, _wr, _oe             host strobes, active low
//   _rxf, _txe                registered host status (RX empty / TX full)
//   data                      shared bidirectional byte bus
//   pc_in_*                   push handshake into RX FIFO
//   pc_out_*                  pop handshake out of TX FIFO
//   proto_err                 sticky protocol violation flags
module ft245_device
  import ft245_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       _rd,
  input  logic       _wr,
  input  logic       _oe,
  output logic       _rxf,
  output logic       _txe,
  inout  wire  [7:0] data,
  input  logic [7:0] pc_in_data,
  input  logic       pc_in_valid,
  output logic       pc_in_ready,
  output logic [7:0] pc_out_data,
  output logic       pc_out_valid,
  input  logic       pc_out_ready,
  output logic [2:0] proto_err
);

  bus_state_e state_q;
  logic       drive_en_q;
  logic       rxf_q, txe_q;
  logic [2:0] err_q, err_d;

  logic       rx_full, rx_empty, rx_empty_next, rx_full_next;
  logic       tx_full, tx_empty, tx_empty_next, tx_full_next;
  logic [7:0] rx_head, tx_head;
  logic       host_pop, host_push;
  logic       unused_flags;

  assign host_pop  = !_rd && _wr && !rxf_q && (state_q == B_DRIVE);
  assign host_push = !_wr && _rd && !txe_q && (state_q == B_IDLE);

  ft245_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk          (clk),
    .rst_n        (_reset),
    .push_i       (pc_in_valid),
    .push_data_i  (pc_in_data),
    .pop_i        (host_pop),
    .head_o       (rx_head),
    .full_o       (rx_full),
    .empty_o      (rx_empty),
    .full_next_o  (rx_full_next),
    .empty_next_o (rx_empty_next)
  );

  ft245_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk          (clk),
    .rst_n        (_reset),
    .push_i       (host_push),
    .push_data_i  (data),
    .pop_i        (pc_out_ready),
    .head_o       (tx_head),
    .full_o       (tx_full),
    .empty_o      (tx_empty),
    .full_next_o  (tx_full_next),
    .empty_next_o (tx_empty_next)
  );

  // Host status only needs RX emptiness and TX fullness.
  assign unused_flags = rx_full_next ^ tx_empty_next ^ tx_full;

  assign pc_in_ready  = !rx_full;
  assign pc_out_valid = !tx_empty;
  assign pc_out_data  = tx_head;

  assign data = drive_en_q ? (rx_empty ? 8'h00 : rx_head) : 8'hzz;

  always_comb begin
    err_d = err_q;
    if (!_rd && !_wr) begin
      err_d[ERR_RD_WR] = 1'b1;
    end else if (!_rd) begin
      if (state_q != B_DRIVE) err_d[ERR_RD_NO_OE] = 1'b1;
    end else if (!_wr) begin
      if (txe_q || (state_q != B_IDLE)) err_d[ERR_WR_FULL] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rxf_q <= 1'b1;
      txe_q <= 1'b1;
      err_q <= '0;
    end else begin
      rxf_q <= rx_empty_next;
      txe_q <= tx_full_next;
      err_q <= err_d;
    end
  end

  // Bus FSM: one turnaround cycle before the device takes the bus.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= B_IDLE;
      drive_en_q <= 1'b0;
    end else begin
      case (state_q)
        B_IDLE: begin
          if (!_oe) state_q <= B_TURN;
        end
        B_TURN: begin
          if (!_oe) begin
            state_q    <= B_DRIVE;
            drive_en_q <= 1'b1;
          end else begin
            state_q <= B_IDLE;
          end
        end
        B_DRIVE: begin
          if (_oe) begin
            state_q    <= B_IDLE;
            drive_en_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= B_IDLE;
          drive_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign _rxf      = rxf_q;
  assign _txe      = txe_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_ft245_device.sv
// tb/tb_ft245_device.sv - scoreboard bench for ft245_device
module tb_ft245_device;

  logic       clk = 1'b0;
  logic       rst_n, rd_n, wr_n, oe_n;
  logic       host_drive;
  logic [7:0] host_data;
  logic [7:0] pc_in_data;
  logic       pc_in_valid, pc_out_ready;
  logic       rxf_n, txe_n, pc_in_ready, pc_out_valid;
  logic [7:0] pc_out_data;
  logic [2:0] proto_err;
  wire  [7:0] data;

  // Undriven bus floats to 0xFF through the pull-up; test bytes avoid 0xFF.
  localparam logic [7:0] HIZ = 8'hFF;

  assign data = host_drive ? host_data : 8'hzz;
  pullup (data);

  always #5 clk = ~clk;

  ft245_device #(.DEPTH(16)) dut (
    .clk          (clk),
    ._reset       (rst_n),
    ._rd          (rd_n),
    ._wr          (wr_n),
    ._oe          (oe_n),
    ._rxf         (rxf_n),
    ._txe         (txe_n),
    .data         (data),
    .pc_in_data   (pc_in_data),
    .pc_in_valid  (pc_in_valid),
    .pc_in_ready  (pc_in_ready),
    .pc_out_data  (pc_out_data),
    .pc_out_valid (pc_out_valid),
    .pc_out_ready (pc_out_ready),
    .proto_err    (proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pc_push(input logic [7:0] b);
    pc_in_valid = 1'b1;
    pc_in_data  = b;
    rx_exp.push_back(b);
    step();
    pc_in_valid = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] b);
    wr_n       = 1'b0;
    host_drive = 1'b1;
    host_data  = b;
    tx_exp.push_back(b);
    step();
    wr_n       = 1'b1;
    host_drive = 1'b0;
  endtask

  // Leaves _rd low so back-to-back calls form a burst.
  task automatic host_read(input string tag);
    logic [7:0] e;
    rd_n = 1'b0;
    e = rx_exp.pop_front();
    check_eq(tag, {24'd0, data}, {24'd0, e});
    step();
  endtask

  task automatic enter_drive();
    oe_n = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1;
    host_drive = 1'b0; host_data = 8'h00;
    pc_in_data = 8'h00; pc_in_valid = 1'b0; pc_out_ready = 1'b0;

    // Reset state
    #12;
    check_eq("rst rxf", rxf_n, 1);
    check_eq("rst txe", txe_n, 1);
    check_eq("rst err", proto_err, 0);
    check_eq("rst pc_in_ready", pc_in_ready, 1);
    check_eq("rst pc_out_valid", pc_out_valid, 0);
    check_eq("rst data hiz", data, HIZ);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post-rst txe", txe_n, 0);
    check_eq("post-rst rxf", rxf_n, 1);

    // Single byte PC -> host
    pc_push(8'hA5);
    check_eq("a5 rxf low", rxf_n, 0);
    oe_n = 1'b0;
    step();
    check_eq("turn data hiz", data, HIZ);
    step();
    host_read("a5 read");
    rd_n = 1'b1;
    check_eq("a5 rxf high", rxf_n, 1);
    check_eq("drive empty data", data, 8'h00);
    oe_n = 1'b1;
    step();
    check_eq("release data hiz", data, HIZ);
    check_eq("a5 err", proto_err, 0);

    // 16 host writes fill TX, 17th dropped
    for (int i = 1; i <= 16; i++) begin
      wr_n = 1'b0; host_drive = 1'b1; host_data = 8'(i);
      tx_exp.push_back(8'(i));
      step();
    end
    check_eq("tx full txe", txe_n, 1);
    host_data = 8'h11;
    step();
    wr_n = 1'b1; host_drive = 1'b0;
    check_eq("wr full err", proto_err, 3'b010);
    pc_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("tx drain valid", pc_out_valid, 1);
      check_eq("tx drain data", pc_out_data, tx_exp.pop_front());
      step();
    end
    pc_out_ready = 1'b0;
    check_eq("tx drained valid", pc_out_valid, 0);
    check_eq("tx drained txe", txe_n, 0);

    // _rd without _oe: no pop, bus stays released
    pc_push(8'h3C);
    rd_n = 1'b0;
    check_eq("rd no oe data hiz", data, HIZ);
    step();
    rd_n = 1'b1;
    check_eq("rd no oe err", proto_err, 3'b011);
    check_eq("rd no oe rxf", rxf_n, 0);

    // Fill RX, then burst-read while PC keeps pushing 0x77
    for (int i = 1; i <= 15; i++) pc_push(8'h40 + 8'(i));
    check_eq("rx full ready", pc_in_ready, 0);
    enter_drive();
    for (int i = 0; i < 20; i++) begin
      pc_in_valid = 1'b1;
      pc_in_data  = 8'h77;
      check_eq("burst rxf", rxf_n, 0);
      if (pc_in_ready) rx_exp.push_back(8'h77);
      host_read("burst data");
    end
    pc_in_valid = 1'b0;
    for (int g = 0; g < 40 && rx_exp.size() > 0; g++) begin
      check_eq("drain rxf", rxf_n, 0);
      host_read("drain data");
    end
    rd_n = 1'b1;
    check_eq("drain leftover", rx_exp.size(), 0);
    check_eq("drain rxf high", rxf_n, 1);

    // Simultaneous host push and PC pop on TX
    oe_n = 1'b1;
    step();
    pc_out_ready = 1'b1;
    wr_n = 1'b0; host_drive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_data = 8'hC0 + 8'(i);
      if (pc_out_valid) check_eq("txsim data", pc_out_data, tx_exp.pop_front());
      tx_exp.push_back(host_data);
      step();
    end
    wr_n = 1'b1; host_drive = 1'b0;
    for (int g = 0; g < 8 && tx_exp.size() > 0; g++) begin
      check_eq("txsim drain valid", pc_out_valid, 1);
      check_eq("txsim drain data", pc_out_data, tx_exp.pop_front());
      step();
    end
    pc_out_ready = 1'b0;
    check_eq("txsim empty", pc_out_valid, 0);

    // Reset in the middle of a read burst
    host_write(8'h5A);
    pc_push(8'h11); pc_push(8'h22); pc_push(8'h33);
    enter_drive();
    host_read("pre-rst read");
    rst_n = 1'b0;
    #1;
    check_eq("midrst data hiz", data, HIZ);
    check_eq("midrst rxf", rxf_n, 1);
    check_eq("midrst txe", txe_n, 1);
    check_eq("midrst pc_in_ready", pc_in_ready, 1);
    check_eq("midrst pc_out_valid", pc_out_valid, 0);
    check_eq("midrst err", proto_err, 0);
    rx_exp.delete();
    tx_exp.delete();
    rd_n = 1'b1; oe_n = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check_eq("rerst txe", txe_n, 0);
    check_eq("rerst rxf", rxf_n, 1);

    // _rd and _wr together: nothing transfers
    rd_n = 1'b0; wr_n = 1'b0; host_drive = 1'b1; host_data = 8'h99;
    step();
    rd_n = 1'b1; wr_n = 1'b1; host_drive = 1'b0;
    check_eq("rdwr err bit", proto_err[2], 1);
    check_eq("rdwr no tx", pc_out_valid, 0);
    step();
    step();
    check_eq("err sticky", proto_err[2], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
